// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receive controller driven by an external start-edge pulse.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity checked before the stop bit).
`default_nettype none

module uart_rx_ctrl #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       start_edge,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             stop_ok;

`ifdef UART_RX_PARITY_EN
  logic parity_err;
  assign stop_ok = rx & ~parity_err;
`else
  assign stop_ok = rx;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // Only the detector pulse opens a frame; a low rx level alone does not.
          if (start_edge) begin
            state    <= START;
            baud_cnt <= '0;
            rx_busy  <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt == CNT_HALF) begin
            baud_cnt <= '0;
            if (!rx) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {rx, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt   <= '0;
            parity_err <= ^{shift_reg, rx};
            state      <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            rx_busy  <= 1'b0;
            if (stop_ok) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames on the RX line checked every cycle against a frame-level timing model.
`default_nettype none

module tb_uart_rx_ctrl;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int N    = 4096;
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 10;
  localparam int LIT = 169;
`else
  localparam int NB  = 9;
  localparam int LIT = 153;
`endif
  localparam int LAT = HALF + NB * CPB + 1;

  localparam int S_VALID = 0;
  localparam int S_FERR  = 1;
  localparam int S_BUSY  = 2;
  localparam int S_DATA  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       start_edge = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx_ctrl #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .start_edge (start_edge),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       exp_valid [N];
  logic       exp_ferr  [N];
  logic       exp_busy  [N];
  logic [7:0] exp_data  [N];

  typedef struct {
    int         at;
    int         sel;
    logic [7:0] val;
  } pin_t;
  pin_t pins[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  // Frame-level model: strobe lands LAT cycles after the start edge, busy spans the frame.
  task automatic model_frame(input int t0, input logic [7:0] b, input bit good);
    int s;
    s = t0 + LAT;
    for (int t = t0 + 1; t < s; t++) exp_busy[t] = 1'b1;
    if (good) begin
      exp_valid[s] = 1'b1;
      for (int t = s; t < N; t++) exp_data[t] = b;
    end else begin
      exp_ferr[s] = 1'b1;
    end
  endtask

  task automatic model_false_start(input int t0);
    for (int t = t0 + 1; t <= t0 + HALF; t++) exp_busy[t] = 1'b1;
  endtask

  task automatic model_reset(input int r);
    for (int t = r; t < N; t++) begin
      exp_valid[t] = 1'b0;
      exp_ferr[t]  = 1'b0;
      exp_busy[t]  = 1'b0;
      exp_data[t]  = 8'h00;
    end
  endtask

  task automatic pin(input int at, input int sel, input logic [7:0] val);
    pin_t p;
    p.at  = at;
    p.sel = sel;
    p.val = val;
    pins.push_back(p);
  endtask

  // Drives the line for n cycles; start_edge mimics the upstream falling-edge detector.
  task automatic line(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      start_edge = rx & ~v;
      rx = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopv, input int stop_len,
                            input bit par_flip);
    bit good;
    logic pbit;
    pbit = (^b) ^ par_flip;
    good = stopv && !par_flip;
`ifndef UART_RX_PARITY_EN
    good = stopv;
`endif
    model_frame(cyc, b, good);
    line(1'b0, CPB);
    for (int k = 0; k < 8; k++) line(b[k], CPB);
`ifdef UART_RX_PARITY_EN
    line(pbit, CPB);
`endif
    line(stopv, stop_len);
  endtask

  always @(negedge clk) begin
    if (!done && cyc < N) begin
      n_cmp++;
      if (rx_valid !== exp_valid[cyc] || frame_err !== exp_ferr[cyc] ||
          rx_busy !== exp_busy[cyc] || rx_data !== exp_data[cyc]) begin
        n_bad++;
        $display("FAIL model cyc%0d: got valid=%b ferr=%b busy=%b data=%h, want valid=%b ferr=%b busy=%b data=%h",
                 cyc, rx_valid, frame_err, rx_busy, rx_data,
                 exp_valid[cyc], exp_ferr[cyc], exp_busy[cyc], exp_data[cyc]);
      end
      foreach (pins[i]) begin
        if (pins[i].at == cyc) begin
          logic [7:0] got;
          case (pins[i].sel)
            S_VALID: got = {7'd0, rx_valid};
            S_FERR:  got = {7'd0, frame_err};
            S_BUSY:  got = {7'd0, rx_busy};
            default: got = rx_data;
          endcase
          n_cmp++;
          if (got !== pins[i].val) begin
            n_bad++;
            $display("FAIL pin%0d cyc%0d: got %h, want %h", pins[i].sel, cyc, got, pins[i].val);
          end
        end
      end
    end
  end

  initial begin
    int t0;
    int t1;
    int r;
    logic [7:0] b5a;

    for (int t = 0; t < N; t++) begin
      exp_valid[t] = 1'b0;
      exp_ferr[t]  = 1'b0;
      exp_busy[t]  = 1'b0;
      exp_data[t]  = 8'h00;
    end

    pin(1, S_BUSY, 8'h00);
    pin(2, S_DATA, 8'h00);
    pin(2, S_VALID, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    line(1'b1, 4);

    // Good byte A5
    t0 = cyc;
    pin(t0, S_BUSY, 8'h00);
    pin(t0 + 1, S_BUSY, 8'h01);
    pin(t0 + LIT - 1, S_VALID, 8'h00);
    pin(t0 + LIT, S_VALID, 8'h01);
    pin(t0 + LIT, S_DATA, 8'hA5);
    pin(t0 + LIT, S_FERR, 8'h00);
    pin(t0 + LIT, S_BUSY, 8'h00);
    pin(t0 + LIT + 1, S_VALID, 8'h00);
    send_frame(8'hA5, 1'b1, CPB, 1'b0);
    line(1'b1, 8);

    // False start
    t0 = cyc;
    model_false_start(t0);
    pin(t0 + 8, S_BUSY, 8'h01);
    pin(t0 + 9, S_BUSY, 8'h00);
    line(1'b0, 3);
    line(1'b1, 30);

    // Framing error on 3C
    t0 = cyc;
    pin(t0 + LIT, S_FERR, 8'h01);
    pin(t0 + LIT, S_VALID, 8'h00);
    pin(t0 + LIT, S_DATA, 8'hA5);
    send_frame(8'h3C, 1'b0, CPB, 1'b0);
    line(1'b1, 20);

    // Back-to-back 00 then FF, second start edge in the strobe cycle
    t0 = cyc;
    pin(t0 + LIT, S_VALID, 8'h01);
    pin(t0 + LIT, S_DATA, 8'h00);
    send_frame(8'h00, 1'b1, HALF + 1, 1'b0);
    t1 = cyc;
    pin(t1 + LIT, S_VALID, 8'h01);
    pin(t1 + LIT, S_DATA, 8'hFF);
    send_frame(8'hFF, 1'b1, CPB, 1'b0);
    line(1'b1, 8);

    // Reset during data bit 4 of 5A, then 81
    b5a = 8'h5A;
    t0 = cyc;
    model_frame(t0, 8'h5A, 1'b1);
    line(1'b0, CPB);
    for (int k = 0; k < 4; k++) line(b5a[k], CPB);
    line(b5a[4], 5);
    r = cyc;
    model_reset(r);
    pin(r, S_DATA, 8'h00);
    pin(r, S_BUSY, 8'h00);
    rst = 1'b0;
    line(1'b1, 3);
    rst = 1'b1;
    line(1'b1, 5);
    t0 = cyc;
    pin(t0 + LIT, S_VALID, 8'h01);
    pin(t0 + LIT, S_DATA, 8'h81);
    send_frame(8'h81, 1'b1, CPB, 1'b0);
    line(1'b1, 8);

    // 07: correct parity, then flipped parity (plain good frames without parity)
    t0 = cyc;
    pin(t0 + LIT, S_VALID, 8'h01);
    pin(t0 + LIT, S_DATA, 8'h07);
    send_frame(8'h07, 1'b1, CPB, 1'b0);
    line(1'b1, 8);
`ifdef UART_RX_PARITY_EN
    t0 = cyc;
    pin(t0 + 169, S_FERR, 8'h01);
    pin(t0 + 169, S_VALID, 8'h00);
    send_frame(8'h07, 1'b1, CPB, 1'b1);
    line(1'b1, 8);
`endif

    line(1'b1, 20);
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- UART receive controller. Sits directly downstream of the falling-edge detector on the RX pin.
- Consumes the detector's one-cycle high-to-low pulse as the start-bit trigger, plus the same synchronized RX level.
- Times the frame with a baud counter, samples each bit at mid-bit, and deserializes 8N1 (LSB first).
- Presents the received byte with a one-cycle valid strobe, or a one-cycle framing-error strobe, to the application logic.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- Derived localparams, not overridable:
  - CPB = CLK_FREQ/BAUD, integer division; must be >= 4.
  - HALF = CPB/2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rx  input  1  RX line level, already synchronized to clk; the same signal that feeds the edge detector.
- start_edge  input  1  one-cycle pulse on an RX high-to-low transition.
- rx_data  output  8  last good received byte; holds until the next good frame.
- rx_valid  output  1  one-cycle strobe: rx_data updated this cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low (or parity bad, see macro).
- rx_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; baud counter, bit index and shift register = 0.
  - rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0.
- States: IDLE, START, DATA, STOP (PARITY only with macro). All state/output registers are clocked.
- Baud counter: clears on every state entry and after every bit sample; otherwise +1 per clock in non-IDLE states. Width ceil(log2(CPB)); never wraps past CPB-1.
- IDLE:
  - start_edge=1 -> START, counter=0.
  - rx alone never starts a frame.
- START:
  - At counter==HALF-1, sample rx.
  - rx=0 -> DATA, bit index=0.
  - rx=1 -> false start: back to IDLE, no strobe of any kind.
- DATA:
  - At counter==CPB-1, sample rx.
  - Shift right into the shift register, so the sampled bit becomes the MSB (LSB-first line order).
  - Bit index +1; after index 7 is sampled -> STOP.
- STOP: at counter==CPB-1, sample rx, then -> IDLE in the same edge.
  - rx=1: rx_data<=shift register, rx_valid=1 for one cycle.
  - rx=0: frame_err=1 for one cycle; rx_data unchanged.
- Timing, with T0 = the cycle start_edge is seen in IDLE:
  - Start sample at T0+HALF.
  - Data bit k (k=0..7) sampled at T0+HALF+(k+1)*CPB.
  - Stop sample at T0+HALF+9*CPB.
  - rx_valid/frame_err high during cycle T0+HALF+9*CPB+1.
  - rx_busy rises at T0+1 and falls in the same cycle as the strobe.
- start_edge while not IDLE: ignored, including edges produced by data bits.
- Back-to-back frames: the next frame's start_edge may arrive in the cycle the strobe is high (IDLE already entered) and must be accepted.
- rx_valid and frame_err are mutually exclusive; never both high.
- Reset mid-frame: immediate return to reset values; the partial byte is discarded and no strobe is issued.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1.
  - After data bit 7 -> PARITY state, sampled at counter==CPB-1.
  - Parity error when XOR(data bits, parity bit) != 0.
  - STOP is still sampled in all cases.
  - Parity error or bad stop -> frame_err, rx_data unchanged; else rx_valid.
  - Strobe moves one CPB later: T0+HALF+10*CPB+1.
- Undefined: no PARITY state, no parity logic; 8N1 timing exactly as above.

Test Plan:
- All tests use CLK_FREQ=1600, BAUD=100, so CPB=16, HALF=8.
- Good byte: send 8'hA5 (8N1) with start_edge at T0 -> rx_valid=1 and rx_data=8'hA5 at T0+153 only; frame_err stays 0.
- False start: rx low 3 cycles with one start_edge, then high -> back to IDLE at T0+8; no strobe; rx_busy low from T0+9.
- Framing error: send 8'h3C with stop bit low -> frame_err=1 at T0+153; rx_data keeps its previous value 8'hA5.
- Back-to-back: 8'h00 then 8'hFF, second start_edge in the strobe cycle -> two rx_valid pulses with data 00 then FF; no frame_err.
- Reset mid-frame: assert rst low during data bit 4 of 8'h5A, release, then send 8'h81 -> all outputs 0 during reset; only one rx_valid, with data 8'h81.
- With UART_RX_PARITY_EN: 8'h07 with parity=1 -> rx_valid at T0+169; same byte with parity=0 -> frame_err at T0+169.
